// File: rtl/seu_inject_ctrl.sv
// seu_inject_ctrl: sequencer for the per-flip-flop SEU injection hooks.
// It fires a one-cycle one-hot flip request, watches MISMATCH for WINDOW
// cycles, and counts each injection as detected or masked.
// Optional feature macro: SEU_INJ_RANDOM_EN (MODE=10 picks targets from a
// 16-bit Fibonacci LFSR; without it MODE=10 behaves as fixed mode).
module seu_inject_ctrl #(
  parameter int          NUM_FF    = 16,
  parameter int          SEL_W     = 4,
  parameter int          WINDOW    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              START,
  input  logic              ABORT,
  input  logic [1:0]        MODE,
  input  logic [SEL_W-1:0]  TARGET,
  input  logic [15:0]       COUNT,
  input  logic              MISMATCH,
  output logic [NUM_FF-1:0] SEU_VEC,
  output logic [SEL_W-1:0]  CUR_TARGET,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [15:0]       DET_CNT,
  output logic [15:0]       MASK_CNT
);

  localparam int               OBS_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [SEL_W:0]   NUM_FF_X = (SEL_W+1)'(NUM_FF);
  localparam logic [SEL_W-1:0] LAST_FF  = SEL_W'(NUM_FF - 1);
  localparam logic [OBS_W-1:0] OBS_LAST = OBS_W'(WINDOW - 1);
  localparam logic [15:0]      SAT      = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_INJECT,
    S_OBSERVE,
    S_LOG
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [15:0]      remaining;
  logic [OBS_W-1:0] obs_cnt;
  logic             sticky;
  logic [SEL_W-1:0] next_target;
  logic             accept, reject, zero_run, log_step, finish;

  // A zero seed would lock the LFSR; such a build shows up as this named block.
  if (LFSR_SEED == 16'h0000) begin : g_zero_seed_invalid
  end

`ifdef SEU_INJ_RANDOM_EN
  logic [15:0] lfsr_q;

  // Fold the low LFSR bits into the 0..NUM_FF-1 target range.
  function automatic logic [SEL_W-1:0] fold_target(input logic [SEL_W-1:0] low_bits);
    logic [SEL_W:0] v;
    v = {1'b0, low_bits};
    if (v >= NUM_FF_X) v = v - NUM_FF_X;
    return v[SEL_W-1:0];
  endfunction

  // LFSR (taps 16,14,13,11) advances once per ARM cycle; START never reseeds it.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q == S_ARM && !ABORT) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end
`endif

  // Target for every injection after the first, chosen by the latched mode.
  always_comb begin
    next_target = CUR_TARGET;
    if (mode_q == 2'b01) begin
      next_target = (CUR_TARGET == LAST_FF) ? '0 : CUR_TARGET + SEL_W'(1);
    end
`ifdef SEU_INJ_RANDOM_EN
    else if (mode_q == 2'b10) begin
      next_target = fold_target(lfsr_q[SEL_W-1:0]);
    end
`endif
  end

  // State register.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and one-cycle control strobes; ABORT overrides everything.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    zero_run = 1'b0;
    log_step = 1'b0;
    finish   = 1'b0;
    if (ABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            if ({1'b0, TARGET} >= NUM_FF_X) begin
              reject = 1'b1;
            end else if (COUNT == 16'd0) begin
              zero_run = 1'b1;
            end else begin
              accept  = 1'b1;
              state_d = S_ARM;
            end
          end
        end
        S_ARM:     state_d = S_INJECT;
        S_INJECT:  state_d = S_OBSERVE;
        S_OBSERVE: if (obs_cnt == OBS_LAST) state_d = S_LOG;
        S_LOG: begin
          log_step = 1'b1;
          if (remaining == 16'd1) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ARM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs, campaign bookkeeping and the observation window.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      SEU_VEC    <= '0;
      CUR_TARGET <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      DET_CNT    <= '0;
      MASK_CNT   <= '0;
      mode_q     <= '0;
      remaining  <= '0;
      obs_cnt    <= '0;
      sticky     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      SEU_VEC <= (state_d == S_INJECT) ? (NUM_FF'(1) << CUR_TARGET) : '0;
      if (ABORT) BUSY <= 1'b0;
      if (accept) begin
        mode_q     <= MODE;
        remaining  <= COUNT;
        CUR_TARGET <= TARGET;
        DET_CNT    <= '0;
        MASK_CNT   <= '0;
        BUSY       <= 1'b1;
      end
      if (zero_run) begin
        DONE     <= 1'b1;
        DET_CNT  <= '0;
        MASK_CNT <= '0;
      end
      if (reject) ERR <= 1'b1;
      if (state_q == S_INJECT) begin
        obs_cnt <= '0;
        sticky  <= 1'b0;
      end else if (state_q == S_OBSERVE) begin
        obs_cnt <= obs_cnt + OBS_W'(1);
        sticky  <= sticky | MISMATCH;
      end
      if (log_step) begin
        if (sticky) begin
          if (DET_CNT != SAT) DET_CNT <= DET_CNT + 16'd1;
        end else begin
          if (MASK_CNT != SAT) MASK_CNT <= MASK_CNT + 16'd1;
        end
        remaining <= remaining - 16'd1;
        if (finish) begin
          DONE <= 1'b1;
          BUSY <= 1'b0;
        end else begin
          CUR_TARGET <= next_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_seu_inject_ctrl.sv
// tb_seu_inject_ctrl: directed plus randomized campaigns for seu_inject_ctrl,
// checked against a campaign-level timeline model (period WINDOW+3, ARM at
// offset 0, INJECT at 1, OBSERVE at 2..WINDOW+1, LOG at WINDOW+2).
module tb_seu_inject_ctrl;

  localparam int          NUM_FF = 16;
  localparam int          SEL_W  = 5;
  localparam int          WINDOW = 8;
  localparam int          P      = WINDOW + 3;
  localparam logic [15:0] SEED   = 16'hACE1;
`ifdef SEU_INJ_RANDOM_EN
  localparam bit RAND_EN = 1'b1;
`else
  localparam bit RAND_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RN = 1'b1;
  logic              START = 1'b0;
  logic              ABORT = 1'b0;
  logic [1:0]        MODE = '0;
  logic [SEL_W-1:0]  TARGET = '0;
  logic [15:0]       COUNT = '0;
  logic              MISMATCH = 1'b0;
  logic [NUM_FF-1:0] SEU_VEC;
  logic [SEL_W-1:0]  CUR_TARGET;
  logic              BUSY, DONE, ERR;
  logic [15:0]       DET_CNT, MASK_CNT;

  seu_inject_ctrl #(
    .NUM_FF(NUM_FF), .SEL_W(SEL_W), .WINDOW(WINDOW), .LFSR_SEED(SEED)
  ) dut (
    .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT), .MODE(MODE),
    .TARGET(TARGET), .COUNT(COUNT), .MISMATCH(MISMATCH), .SEU_VEC(SEU_VEC),
    .CUR_TARGET(CUR_TARGET), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .DET_CNT(DET_CNT), .MASK_CNT(MASK_CNT)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [15:0] lfsr_m = SEED;
  int          exp_det = 0;
  int          exp_mask = 0;
  bit          plan [0:1023];
  int          tgt [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int fold(input logic [15:0] s);
    int low;
    low = int'(s) % (1 << SEL_W);
    if (low >= NUM_FF) low = low - NUM_FF;
    return low;
  endfunction

  task automatic clear_plan();
    for (int k = 0; k < 1024; k++) plan[k] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " seu_vec"}, 32'(SEU_VEC), 32'd0);
    check({tag, " cur_target"}, 32'(CUR_TARGET), 32'd0);
    check({tag, " busy"}, 32'(BUSY), 32'd0);
    check({tag, " done"}, 32'(DONE), 32'd0);
    check({tag, " err"}, 32'(ERR), 32'd0);
    check({tag, " det"}, 32'(DET_CNT), 32'd0);
    check({tag, " mask"}, 32'(MASK_CNT), 32'd0);
  endtask

  // One full campaign; MISMATCH follows plan[] by cycle offset from the START edge.
  task automatic run_campaign(input logic [1:0] mode, input int t, input int n, input string name);
    int  kind, det, mask, i;
    bit  hit, active;
    kind = (mode == 2'b01) ? 1 : ((mode == 2'b10 && RAND_EN) ? 2 : 0);
    for (int j = 0; j < n; j++) begin
      if (j == 0)         tgt[j] = t;
      else if (kind == 1) tgt[j] = (tgt[j-1] + 1) % NUM_FF;
      else if (kind == 2) tgt[j] = fold(lfsr_m);
      else                tgt[j] = t;
      lfsr_m = lfsr_step(lfsr_m);
    end
    det = 0;
    mask = 0;
    for (int j = 0; j < n; j++) begin
      hit = 1'b0;
      for (int k = j*P + 2; k <= j*P + 1 + WINDOW; k++) hit = hit | plan[k];
      if (hit) det = det + 1;
      else     mask = mask + 1;
    end
    @(negedge CLK);
    START = 1'b1; MODE = mode; TARGET = SEL_W'(t); COUNT = 16'(n);
    @(negedge CLK);
    START = 1'b0;
    for (int k = 0; k <= n*P + 1; k++) begin
      active = (k < n*P);
      i = active ? k / P : n - 1;
      check({name, " seu_vec"}, 32'(SEU_VEC), (active && (k % P == 1)) ? (32'd1 << tgt[i]) : 32'd0);
      check({name, " busy"}, 32'(BUSY), 32'(active));
      check({name, " done"}, 32'(DONE), 32'(k == n*P));
      check({name, " err"}, 32'(ERR), 32'd0);
      check({name, " cur_target"}, 32'(CUR_TARGET), 32'(tgt[i]));
      check({name, " target range"}, 32'(int'(CUR_TARGET) < NUM_FF), 32'd1);
      MISMATCH = plan[k];
      START    = (k == 5);
      TARGET   = (k == 5) ? SEL_W'(31) : SEL_W'(t);
      @(negedge CLK);
    end
    MISMATCH = 1'b0;
    START = 1'b0;
    check({name, " det_cnt"}, 32'(DET_CNT), 32'(det));
    check({name, " mask_cnt"}, 32'(MASK_CNT), 32'(mask));
    exp_det = det;
    exp_mask = mask;
    clear_plan();
  endtask

  initial begin
    int t, m0, n;
    logic [1:0] md;
    clear_plan();

    // Reset values while RN is low and just after release.
    #1 RN = 1'b0;
    #1 check_all_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RN = 1'b1;
    @(negedge CLK);
    check_all_zero("post reset");

    // Fixed mode, no mismatches: three injections at bit 5, DONE 33 cycles after START.
    run_campaign(2'b00, 5, 3, "fixed");

    // Sweep with wrap; one mismatch pulse at the 3rd OBSERVE cycle of injection 2.
    plan[P + 4] = 1'b1;
    run_campaign(2'b01, 14, 4, "sweep");

    // MISMATCH only during INJECT and LOG cycles must not count as detection.
    for (int j = 0; j < 2; j++) begin
      plan[j*P + 1] = 1'b1;
      plan[j*P + 2 + WINDOW] = 1'b1;
    end
    run_campaign(2'b00, 7, 2, "edge mismatch");

    // Out-of-range target: ERR pulse, no BUSY, counters untouched.
    @(negedge CLK);
    START = 1'b1; TARGET = SEL_W'(16 + $urandom_range(0, 15)); COUNT = 16'd3;
    @(negedge CLK);
    START = 1'b0;
    check("bad target err", 32'(ERR), 32'd1);
    check("bad target busy", 32'(BUSY), 32'd0);
    check("bad target det", 32'(DET_CNT), 32'(exp_det));
    check("bad target mask", 32'(MASK_CNT), 32'(exp_mask));
    @(negedge CLK);
    check("bad target err drop", 32'(ERR), 32'd0);
    check("bad target busy hold", 32'(BUSY), 32'd0);

    // COUNT=0: DONE pulse, counters cleared, no injection.
    START = 1'b1; TARGET = SEL_W'(4); COUNT = 16'd0;
    @(negedge CLK);
    START = 1'b0;
    check("zero count done", 32'(DONE), 32'd1);
    check("zero count busy", 32'(BUSY), 32'd0);
    check("zero count det", 32'(DET_CNT), 32'd0);
    check("zero count mask", 32'(MASK_CNT), 32'd0);
    exp_det = 0;
    exp_mask = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("zero count seu_vec", 32'(SEU_VEC), 32'd0);
      check("zero count done drop", 32'(DONE), 32'd0);
    end

    // Randomized fixed/sweep/other-mode campaigns with sparse random mismatches.
    for (int r = 0; r < 4; r++) begin
      md = 2'($urandom_range(0, 3));
      t  = $urandom_range(0, NUM_FF - 1);
      n  = $urandom_range(1, 4);
      for (int k = 0; k < n*P + 2; k++) plan[k] = ($urandom_range(0, 7) == 0);
      run_campaign(md, t, n, "random campaign");
    end

    // ABORT together with a valid START in IDLE: nothing starts, counters hold.
    @(negedge CLK);
    START = 1'b1; ABORT = 1'b1; MODE = 2'b00; TARGET = SEL_W'(2); COUNT = 16'd3;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    check("abort+start busy", 32'(BUSY), 32'd0);
    check("abort+start err", 32'(ERR), 32'd0);
    check("abort+start done", 32'(DONE), 32'd0);
    check("abort+start det", 32'(DET_CNT), 32'(exp_det));
    check("abort+start mask", 32'(MASK_CNT), 32'(exp_mask));
    @(negedge CLK);
    check("abort+start idle", 32'(BUSY), 32'd0);

    // ABORT during INJECT of injection 2 of a 5-injection sweep.
    t  = $urandom_range(0, NUM_FF - 1);
    m0 = $urandom_range(0, 1);
    if (m0 == 1) plan[2 + $urandom_range(0, WINDOW - 1)] = 1'b1;
    START = 1'b1; MODE = 2'b01; TARGET = SEL_W'(t); COUNT = 16'd5;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 0; k <= P; k++) begin
      MISMATCH = plan[k];
      @(negedge CLK);
    end
    MISMATCH = 1'b0;
    check("abort inject seu_vec", 32'(SEU_VEC), 32'd1 << ((t + 1) % NUM_FF));
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    lfsr_m = lfsr_step(lfsr_step(lfsr_m));
    check("abort seu_vec", 32'(SEU_VEC), 32'd0);
    check("abort busy", 32'(BUSY), 32'd0);
    check("abort done", 32'(DONE), 32'd0);
    check("abort det+mask", 32'(DET_CNT) + 32'(MASK_CNT), 32'd1);
    check("abort det", 32'(DET_CNT), 32'(m0));
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      check("after abort done", 32'(DONE), 32'd0);
      check("after abort seu_vec", 32'(SEU_VEC), 32'd0);
      check("after abort busy", 32'(BUSY), 32'd0);
    end
    clear_plan();

    // Reset in the middle of OBSERVE, then a campaign that behaves as from fresh reset.
    START = 1'b1; MODE = 2'b01; TARGET = SEL_W'(3); COUNT = 16'd2;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    check("pre-reset busy", 32'(BUSY), 32'd1);
    RN = 1'b0;
    #1 check_all_zero("mid-observe reset");
    @(negedge CLK);
    RN = 1'b1;
    lfsr_m = SEED;
    plan[2*P + 5] = 1'b1;
    run_campaign(2'b00, 9, 3, "after reset");

    // MODE=10 long campaign: LFSR targets with the random feature, fixed otherwise.
    for (int k = 0; k < 20*P + 2; k++) plan[k] = ($urandom_range(0, 5) == 0);
    run_campaign(2'b10, $urandom_range(0, NUM_FF - 1), 20, "mode10");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
